// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel timing from external syncs,
// locks onto a known raster and emits active-area pixel strobes.
module vga_sync_receiver #(
    parameter int H_TOTAL  = 800,
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] pixel_in,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    output logic [2:0] pix_data,
    output logic       frame_start,
    output logic       locked,
    output logic       timing_err
);

    localparam logic [11:0] H_TOT = 12'(H_TOTAL);
    localparam logic [10:0] H_LO  = 11'(H_START);
    localparam logic [11:0] H_HI  = 12'(H_START + H_ACTIVE);
    localparam logic [10:0] V_TOT = 11'(V_TOTAL);
    localparam logic [9:0]  V_LO  = 10'(V_START);
    localparam logic [10:0] V_HI  = 11'(V_START + V_ACTIVE);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCK   = 2'd2
    } state_t;

    state_t state;

    logic       hs_m, hs_s, vs_m, vs_s;
    logic [2:0] px_m, px_s;
    logic       ce;
    logic       hs_prev, vs_prev;
    logic       hfall, vfall;

    logic [10:0] hcnt, hcnt_nxt;
    logic [9:0]  vcnt, vcnt_nxt;
    logic [11:0] line_len;
    logic [10:0] frame_len;
    logic        mismatch;
    logic        active;

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            hs_m <= 1'b1;
            hs_s <= 1'b1;
            vs_m <= 1'b1;
            vs_s <= 1'b1;
            px_m <= 3'd0;
            px_s <= 3'd0;
            ce   <= 1'b0;
        end else begin
            hs_m <= hsync_in;
            hs_s <= hs_m;
            vs_m <= vsync_in;
            vs_s <= vs_m;
            px_m <= pixel_in;
            px_s <= px_m;
            ce   <= ~ce;
        end
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            hs_prev <= 1'b1;
            vs_prev <= 1'b1;
        end else if (ce) begin
            hs_prev <= hs_s;
            vs_prev <= vs_s;
        end
    end

    assign hfall = ce & hs_prev & ~hs_s;
    assign vfall = ce & vs_prev & ~vs_s;

    // Next-count values index the sample taken on this ce cycle.
    always_comb begin
        hcnt_nxt = hcnt;
        if (hfall)
            hcnt_nxt = 11'd0;
        else if (hcnt != 11'h7ff)
            hcnt_nxt = hcnt + 11'd1;
    end

    always_comb begin
        vcnt_nxt = vcnt;
        if (vfall)
            vcnt_nxt = 10'd0;
        else if (hfall && vcnt != 10'h3ff)
            vcnt_nxt = vcnt + 10'd1;
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            hcnt <= 11'd0;
            vcnt <= 10'd0;
        end else if (ce) begin
            hcnt <= hcnt_nxt;
            vcnt <= vcnt_nxt;
        end
    end

    // A line edge coinciding with the frame edge still closes the old frame.
    assign line_len  = {1'b0, hcnt} + 12'd1;
    assign frame_len = {1'b0, vcnt} + {10'd0, hfall};
    assign mismatch  = (hfall && line_len != H_TOT) ||
                       (vfall && frame_len != V_TOT);

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state      <= SEARCH;
            locked     <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            timing_err <= 1'b0;
            unique case (state)
                SEARCH: begin
                    locked <= 1'b0;
                    if (vfall)
                        state <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        state      <= SEARCH;
                        timing_err <= 1'b1;
                    end else if (vfall) begin
                        state  <= LOCK;
                        locked <= 1'b1;
                    end
                end
                LOCK: begin
                    if (mismatch) begin
                        state      <= SEARCH;
                        locked     <= 1'b0;
                        timing_err <= 1'b1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    assign active = (hcnt_nxt >= H_LO) && ({1'b0, hcnt_nxt} < H_HI) &&
                    (vcnt_nxt >= V_LO) && ({1'b0, vcnt_nxt} < V_HI);

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            pix_x       <= 10'd0;
            pix_y       <= 9'd0;
            pix_data    <= 3'd0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            if (ce && locked && active) begin
                pix_valid   <= 1'b1;
                pix_x       <= 10'(hcnt_nxt - H_LO);
                pix_y       <= 9'(vcnt_nxt - V_LO);
                pix_data    <= px_s;
                frame_start <= (hcnt_nxt == H_LO) && (vcnt_nxt == V_LO);
            end
        end
    end

endmodule
